// File: rtl/hdc_pkg.sv
// Shared sizing and state encoding for the HDC associative-search stage.
package hdc_pkg;

  localparam int FRAME_W   = 64;
  localparam int N_FRAMES  = 3;
  localparam int N_CLASSES = 8;
  localparam int CLASS_W   = 3;
  localparam int FIDX_W    = 2;
  localparam int DIST_W    = 8;
  localparam int POP_W     = $clog2(FRAME_W + 1);

  // Terminal values of the frame and class counters, sized to the counters.
  localparam logic [FIDX_W-1:0]  LAST_FIDX = FIDX_W'(N_FRAMES - 1);
  localparam logic [CLASS_W-1:0] LAST_CLS  = CLASS_W'(N_CLASSES - 1);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/hdc_assoc_search_if.sv
// Query stream, class-ROM address/data and result handshake of the search stage.
interface hdc_assoc_search_if;
  import hdc_pkg::*;

  logic               query_valid;
  logic               query_ready;
  logic [FRAME_W-1:0] query_frame;
  logic [CLASS_W-1:0] frame_id;
  logic [FIDX_W-1:0]  frame_index;
  logic [FRAME_W-1:0] class_vec_in;
  logic               result_valid;
  logic               result_ready;
  logic [CLASS_W-1:0] pred_class;
  logic [DIST_W-1:0]  best_dist;

  // Environment side: produces queries, serves the ROM, consumes predictions.
  modport master (
    output query_valid, query_frame, class_vec_in, result_ready,
    input  query_ready, frame_id, frame_index, result_valid, pred_class, best_dist
  );

  // Search stage side.
  modport slave (
    input  query_valid, query_frame, class_vec_in, result_ready,
    output query_ready, frame_id, frame_index, result_valid, pred_class, best_dist
  );

endinterface

// File: rtl/hdc_popcount.sv
// Combinational Hamming distance between two frames: XOR, per-byte counts,
// then a pairwise adder tree. WIDTH must be a multiple of 8 with a
// power-of-two number of bytes.
module hdc_popcount #(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [CNT_W-1:0] cnt
);

  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] diff;
  logic [CNT_W-1:0] part [NB];

  assign diff = a ^ b;

  // Byte counts first, then fold pairs at doubling strides into part[0].
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      part[i] = '0;
      for (int j = 0; j < 8; j++) begin
        part[i] = part[i] + CNT_W'(diff[8*i+j]);
      end
    end
    for (int s = 1; s < NB; s = s * 2) begin
      for (int i = 0; i + s < NB; i = i + 2 * s) begin
        part[i] = part[i] + part[i+s];
      end
    end
    cnt = part[0];
  end

endmodule

// File: rtl/hdc_assoc_search.sv
// Associative-memory search: buffers one query hypervector, sweeps the class
// ROM one frame per cycle and reports the class at minimum Hamming distance.
//
// state  | meaning
// LOAD   | accepting query frames 0..N_FRAMES-1 into the buffer
// SEARCH | one ROM frame per cycle, accumulating distance per class
// DONE   | prediction valid, held until result_ready
module hdc_assoc_search
  import hdc_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  hdc_assoc_search_if.slave bus
);

  state_t             state, state_nxt;
  logic [FRAME_W-1:0] qbuf [N_FRAMES];
  logic [FIDX_W-1:0]  qidx;
  logic [FIDX_W-1:0]  fidx;
  logic [CLASS_W-1:0] cls;
  logic [DIST_W-1:0]  acc;
  logic [DIST_W-1:0]  dsum;
  logic [POP_W-1:0]   pop;
  logic [CLASS_W-1:0] pred_class;
  logic [DIST_W-1:0]  best_dist;
  logic               beat;
  logic               last_frame;
  logic               last_class;

  assign beat       = bus.query_valid && bus.query_ready;
  assign last_frame = (fidx == LAST_FIDX);
  assign last_class = (cls == LAST_CLS);

  hdc_popcount #(.WIDTH(FRAME_W), .CNT_W(POP_W)) u_popcount (
    .a   (qbuf[fidx]),
    .b   (bus.class_vec_in),
    .cnt (pop)
  );

  assign dsum = acc + DIST_W'(pop);

  // Counters idle at 0 outside SEARCH, so the ROM address rests at 0/0.
  assign bus.frame_id    = cls;
  assign bus.frame_index = fidx;
  assign bus.pred_class  = pred_class;
  assign bus.best_dist   = best_dist;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt        = state;
    bus.query_ready  = 1'b0;
    bus.result_valid = 1'b0;
    case (state)
      LOAD: begin
        bus.query_ready = 1'b1;
        if (bus.query_valid && qidx == LAST_FIDX) state_nxt = SEARCH;
      end
      SEARCH: begin
        if (last_frame && last_class) state_nxt = DONE;
      end
      DONE: begin
        bus.result_valid = 1'b1;
        if (bus.result_ready) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Query buffer, sweep counters, distance accumulator and running minimum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_FRAMES; i++) qbuf[i] <= '0;
      qidx       <= '0;
      fidx       <= '0;
      cls        <= '0;
      acc        <= '0;
      pred_class <= '0;
      best_dist  <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (beat) begin
            qbuf[qidx] <= bus.query_frame;
            qidx       <= (qidx == LAST_FIDX) ? '0 : qidx + 1'b1;
          end
        end
        SEARCH: begin
          if (!last_frame) begin
            acc  <= dsum;
            fidx <= fidx + 1'b1;
          end else begin
            // Strict less-than keeps the lower class index on ties.
            if (cls == '0 || dsum < best_dist) begin
              best_dist  <= dsum;
              pred_class <= cls;
            end
            acc  <= '0;
            fidx <= '0;
            cls  <= last_class ? '0 : cls + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hdc_assoc_search.sv
// Directed bench for hdc_assoc_search with a behavioural class ROM stub:
// class k holds the low 8k bits set in every frame.
module tb_hdc_assoc_search;
  import hdc_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [63:0] rom [8];
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ZEROS = 64'h0;
  localparam logic [63:0] LOW32 = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] LOW20 = 64'h0000_0000_000F_FFFF;

  hdc_assoc_search_if bus ();

  hdc_assoc_search dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_comb bus.class_vec_in = rom[bus.frame_id];

  function automatic logic [63:0] stub_word(input int k);
    logic [63:0] w;
    w = '0;
    for (int b = 0; b < 8 * k; b++) w[b] = 1'b1;
    return w;
  endfunction

  task automatic load_stub();
    for (int k = 0; k < 8; k++) rom[k] = stub_word(k);
  endtask

  // Presents one frame until accepted; returns just after the accepting edge.
  task automatic send_beat(input logic [63:0] f);
    int n;
    n = 0;
    @(negedge clk);
    bus.query_valid = 1'b1;
    bus.query_frame = f;
    while (bus.query_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_cmp++; n_fail++;
      $display("FAIL beat_timeout: query_ready never rose within 100 cycles");
    end
    @(posedge clk); #1;
    bus.query_valid = 1'b0;
  endtask

  task automatic send_query(input logic [63:0] f0, input logic [63:0] f1, input logic [63:0] f2);
    send_beat(f0);
    send_beat(f1);
    send_beat(f2);
  endtask

  task automatic wait_done(output bit ok);
    int n;
    n = 0;
    while (bus.result_valid !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (bus.result_valid === 1'b1);
  endtask

  task automatic take_result();
    @(negedge clk);
    bus.result_ready = 1'b1;
    @(posedge clk); #1;
    bus.result_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.query_ready !== 1'b1) begin n_fail++; $display("FAIL rst_query_ready: got %b want 1", bus.query_ready); end
    n_cmp++; if (bus.result_valid !== 1'b0) begin n_fail++; $display("FAIL rst_result_valid: got %b want 0", bus.result_valid); end
    n_cmp++; if (bus.pred_class !== 3'd0) begin n_fail++; $display("FAIL rst_pred_class: got %0d want 0", bus.pred_class); end
    n_cmp++; if (bus.best_dist !== 8'd0) begin n_fail++; $display("FAIL rst_best_dist: got %0d want 0", bus.best_dist); end
    n_cmp++; if (bus.frame_id !== 3'd0 || bus.frame_index !== 2'd0) begin n_fail++; $display("FAIL rst_addr: got %0d/%0d want 0/0", bus.frame_id, bus.frame_index); end
  endtask

  // All-zeros query: checks the sweep address order and the exact latency
  // (result_valid in the 28th cycle counting the first beat's cycle).
  task automatic test_zeros_latency();
    int addr_bad;
    bit ok;
    addr_bad = 0;
    send_query(ZEROS, ZEROS, ZEROS);
    for (int i = 0; i < 24; i++) begin
      if (bus.frame_id !== 3'(i / 3) || bus.frame_index !== 2'(i % 3) || bus.query_ready !== 1'b0) begin
        addr_bad++;
        $display("FAIL sweep_addr[%0d]: got %0d/%0d qr=%b want %0d/%0d qr=0", i, bus.frame_id, bus.frame_index, bus.query_ready, i / 3, i % 3);
      end
      if (i == 23) begin
        n_cmp++; if (bus.result_valid !== 1'b0) begin n_fail++; $display("FAIL early_valid: got %b want 0 on last sweep cycle", bus.result_valid); end
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (addr_bad != 0) n_fail++;
    n_cmp++; if (bus.result_valid !== 1'b1) begin n_fail++; $display("FAIL latency: result_valid got %b want 1 after 27 edges", bus.result_valid); end
    n_cmp++; if (bus.frame_id !== 3'd0 || bus.frame_index !== 2'd0) begin n_fail++; $display("FAIL done_addr: got %0d/%0d want 0/0", bus.frame_id, bus.frame_index); end
    wait_done(ok);
    n_cmp++; if (bus.pred_class !== 3'd0 || bus.best_dist !== 8'd0) begin n_fail++; $display("FAIL zeros_result: got %0d/%0d want 0/0", bus.pred_class, bus.best_dist); end
    take_result();
    n_cmp++; if (bus.query_ready !== 1'b1 || bus.result_valid !== 1'b0) begin n_fail++; $display("FAIL zeros_release: qr=%b rv=%b want 1/0", bus.query_ready, bus.result_valid); end
  endtask

  // Several query patterns against the standard stub.
  task automatic test_patterns();
    bit ok;
    send_query(ONES, ONES, ONES);
    wait_done(ok);
    n_cmp++; if (!ok || bus.pred_class !== 3'd7 || bus.best_dist !== 8'd24) begin n_fail++; $display("FAIL ones_result: got %0d/%0d valid=%b want 7/24", bus.pred_class, bus.best_dist, ok); end
    take_result();

    send_query(LOW32, LOW32, LOW32);
    wait_done(ok);
    n_cmp++; if (!ok || bus.pred_class !== 3'd4 || bus.best_dist !== 8'd0) begin n_fail++; $display("FAIL low32_result: got %0d/%0d valid=%b want 4/0", bus.pred_class, bus.best_dist, ok); end
    take_result();

    // Classes 2 and 3 both at distance 12: lower index must win.
    send_query(LOW20, LOW20, LOW20);
    wait_done(ok);
    n_cmp++; if (!ok || bus.pred_class !== 3'd2 || bus.best_dist !== 8'd12) begin n_fail++; $display("FAIL low20_tie: got %0d/%0d valid=%b want 2/12", bus.pred_class, bus.best_dist, ok); end
    take_result();

    // Distinct frames: distance 64+|32-8k|, minimum at class 4.
    send_query(ONES, ZEROS, LOW32);
    wait_done(ok);
    n_cmp++; if (!ok || bus.pred_class !== 3'd4 || bus.best_dist !== 8'd64) begin n_fail++; $display("FAIL mixed_frames: got %0d/%0d valid=%b want 4/64", bus.pred_class, bus.best_dist, ok); end
    take_result();
  endtask

  task automatic test_tie();
    bit ok;
    for (int k = 0; k < 8; k++) rom[k] = ZEROS;
    rom[2] = ONES;
    rom[5] = ONES;
    send_query(ONES, ONES, ONES);
    wait_done(ok);
    n_cmp++; if (!ok || bus.pred_class !== 3'd2 || bus.best_dist !== 8'd0) begin n_fail++; $display("FAIL tie_result: got %0d/%0d valid=%b want 2/0", bus.pred_class, bus.best_dist, ok); end
    take_result();
    load_stub();
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad;
    bad = 0;
    send_query(ONES, ONES, ONES);
    wait_done(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL bp_done: result_valid got 0 want 1"); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.query_valid = (i % 2 == 0);
      bus.query_frame = ONES;
      @(posedge clk); #1;
      if (bus.result_valid !== 1'b1 || bus.pred_class !== 3'd7 || bus.best_dist !== 8'd24 || bus.query_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: rv=%b pred=%0d dist=%0d qr=%b want 1/7/24/0", i, bus.result_valid, bus.pred_class, bus.best_dist, bus.query_ready);
      end
    end
    bus.query_valid = 1'b0;
    n_cmp++; if (bad != 0) n_fail++;
    take_result();
    n_cmp++; if (bus.query_ready !== 1'b1 || bus.result_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: qr=%b rv=%b want 1/0", bus.query_ready, bus.result_valid); end
    // Any pulse captured in DONE would corrupt this zeros query.
    send_query(ZEROS, ZEROS, ZEROS);
    wait_done(ok);
    n_cmp++; if (!ok || bus.pred_class !== 3'd0 || bus.best_dist !== 8'd0) begin n_fail++; $display("FAIL bp_after: got %0d/%0d valid=%b want 0/0", bus.pred_class, bus.best_dist, ok); end
    take_result();
  endtask

  task automatic test_reset_mid_search();
    bit ok;
    send_query(ONES, ONES, ONES);
    repeat (10) begin @(posedge clk); #1; end
    n_cmp++; if (bus.query_ready !== 1'b0 || bus.frame_id !== 3'd3 || bus.frame_index !== 2'd1) begin n_fail++; $display("FAIL mid_search_addr: qr=%b addr=%0d/%0d want 0 3/1", bus.query_ready, bus.frame_id, bus.frame_index); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.result_valid !== 1'b0 || bus.query_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_hs: rv=%b qr=%b want 0/1", bus.result_valid, bus.query_ready); end
    n_cmp++; if (bus.frame_id !== 3'd0 || bus.frame_index !== 2'd0) begin n_fail++; $display("FAIL mid_rst_addr: got %0d/%0d want 0/0", bus.frame_id, bus.frame_index); end
    @(negedge clk);
    rst_n = 1'b1;
    send_query(ZEROS, ZEROS, ZEROS);
    wait_done(ok);
    n_cmp++; if (!ok || bus.pred_class !== 3'd0 || bus.best_dist !== 8'd0) begin n_fail++; $display("FAIL post_rst_query: got %0d/%0d valid=%b want 0/0", bus.pred_class, bus.best_dist, ok); end
    take_result();
  endtask

  // Valid pattern 1,0,0,1,0,1; idle cycles carry zeros that must not land.
  task automatic test_gapped_load();
    bit ok;
    bit pat [6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.query_valid = pat[i];
      bus.query_frame = pat[i] ? ONES : ZEROS;
      @(posedge clk); #1;
      if (i == 4) begin
        n_cmp++; if (bus.query_ready !== 1'b1) begin n_fail++; $display("FAIL gap_still_loading: qr=%b want 1 after 2 beats", bus.query_ready); end
      end
    end
    bus.query_valid = 1'b0;
    n_cmp++; if (bus.query_ready !== 1'b0 || bus.frame_id !== 3'd0 || bus.frame_index !== 2'd0) begin n_fail++; $display("FAIL gap_search_start: qr=%b addr=%0d/%0d want 0 0/0", bus.query_ready, bus.frame_id, bus.frame_index); end
    wait_done(ok);
    n_cmp++; if (!ok || bus.pred_class !== 3'd7 || bus.best_dist !== 8'd24) begin n_fail++; $display("FAIL gap_result: got %0d/%0d valid=%b want 7/24", bus.pred_class, bus.best_dist, ok); end
    take_result();
  endtask

  initial begin
    bus.query_valid  = 1'b0;
    bus.query_frame  = '0;
    bus.result_ready = 1'b0;
    load_stub();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_zeros_latency();
    test_patterns();
    test_tie();
    test_backpressure();
    test_reset_mid_search();
    test_gapped_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
